// File: rtl/guess_seq_ctrl.sv
// guess_seq_ctrl: single-clock sequencer for the two-player guess-number game
module guess_seq_ctrl #(
   parameter int MAX_LEN   = 7,
   parameter int MIN_LEN   = 4,
   parameter int MAX_TURNS = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       i1_i,
   input  logic       i2_i,
   input  logic       i3_i,
   input  logic       i4_i,
   input  logic       enter_i,
   output logic [3:0] nums_o,
   output logic       win_o,
   output logic       lose_o,
   output logic       equal_o,
   output logic       bigger_o,
   output logic       smaller_o,
   output logic       busy_o,
   output logic [1:0] turn_o,
   output logic [1:0] phase_o
);
   typedef enum logic [1:0] {SECRET = 2'd0, GUESS = 2'd1, COMPARE = 2'd2, DONE = 2'd3} state_t;
   localparam logic [3:0] ML = 4'(MAX_LEN);
   localparam logic [3:0] MN = 4'(MIN_LEN);
   localparam logic [1:0] MT = 2'(MAX_TURNS);
   state_t           state_q, state_d;
   logic [4:0]       prev_q, lvl, ev;
   logic [15:0][1:0] sec_q, sec_d, gss_q, gss_d;
   logic [3:0]       len_a_q, len_a_d, len_b_q, len_b_d, idx_q, idx_d;
   logic [3:0]       nums_q, nums_d, onehot, cmp_len;
   logic [1:0]       turn_q, turn_d, code;
   logic             match_q, match_d, win_q, win_d, lose_q, lose_d;
   logic             eq_q, eq_d, big_q, big_d, sml_q, sml_d;
   logic             sym_ev, ent_ev, m, last;
   assign lvl     = {enter_i, i4_i, i3_i, i2_i, i1_i};
   assign ev      = lvl & ~prev_q;
   assign sym_ev  = |ev[3:0];
   assign ent_ev  = ev[4] & ~sym_ev;
   assign code    = ev[0] ? 2'd0 : ev[1] ? 2'd1 : ev[2] ? 2'd2 : 2'd3;
   assign onehot  = 4'b0001 << code;
   assign cmp_len = eq_q ? len_a_q : 4'd1;
   assign last    = idx_q == cmp_len - 4'd1;
   assign m       = match_q & (sec_q[idx_q] == gss_q[idx_q]);
   assign nums_o    = nums_q;
   assign win_o     = win_q;
   assign lose_o    = lose_q;
   assign equal_o   = eq_q;
   assign bigger_o  = big_q;
   assign smaller_o = sml_q;
   assign busy_o    = state_q == COMPARE;
   assign turn_o    = turn_q;
   assign phase_o   = state_q;
   // next state: key entry, guess commit and symbol-serial compare
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      gss_d   = gss_q;
      len_a_d = len_a_q;
      len_b_d = len_b_q;
      idx_d   = idx_q;
      match_d = match_q;
      nums_d  = nums_q;
      turn_d  = turn_q;
      win_d   = win_q;
      lose_d  = lose_q;
      eq_d    = eq_q;
      big_d   = big_q;
      sml_d   = sml_q;
      case (state_q)
         SECRET: begin
            if (sym_ev) begin
               nums_d = onehot;
               if (len_a_q < ML) begin
                  sec_d[len_a_q] = code;
                  len_a_d        = len_a_q + 4'd1;
               end
            end else if (ent_ev) begin
               if (len_a_q >= MN) begin
                  state_d = GUESS;
                  len_b_d = 4'd0;
               end else
                  len_a_d = 4'd0;
            end
         end
         GUESS: begin
            if (sym_ev) begin
               nums_d = onehot;
               if (len_b_q < ML) begin
                  gss_d[len_b_q] = code;
                  len_b_d        = len_b_q + 4'd1;
               end
            end else if (ent_ev) begin
               if (len_b_q >= MN) begin
                  eq_d    = len_b_q == len_a_q;
                  sml_d   = len_b_q > len_a_q;
                  big_d   = len_b_q < len_a_q;
                  match_d = len_b_q == len_a_q;
                  idx_d   = 4'd0;
                  state_d = COMPARE;
               end else
                  len_b_d = 4'd0;
            end
         end
         COMPARE: begin
            match_d = m;
            idx_d   = idx_q + 4'd1;
            if (last) begin
               if (m) begin
                  win_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  turn_d = turn_q + 2'd1;
                  if (turn_q + 2'd1 == MT) begin
                     lose_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     len_b_d = 4'd0;
                     state_d = GUESS;
                  end
               end
            end
         end
         default: ;
      endcase
   end
   // state register with synchronous active-low clear; prev tracks button levels
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= SECRET;
         prev_q  <= '0;
         sec_q   <= '0;
         gss_q   <= '0;
         len_a_q <= '0;
         len_b_q <= '0;
         idx_q   <= '0;
         match_q <= 1'b0;
         nums_q  <= '0;
         turn_q  <= '0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         eq_q    <= 1'b0;
         big_q   <= 1'b0;
         sml_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= lvl;
         sec_q   <= sec_d;
         gss_q   <= gss_d;
         len_a_q <= len_a_d;
         len_b_q <= len_b_d;
         idx_q   <= idx_d;
         match_q <= match_d;
         nums_q  <= nums_d;
         turn_q  <= turn_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         eq_q    <= eq_d;
         big_q   <= big_d;
         sml_q   <= sml_d;
      end
   end
endmodule
